stoch_matrix_decode: RTL and testbench
======================================

// Module: stoch_matrix_decode
// PURPOSE
//  Reader end of the stochastic matrix datapath: integrates a NUM_ROWS x NUM_COLS
//  matrix of signed stochastic bitstreams over a fixed window of 2**WINDOW_LOG2
//  cycles. Each stream is a pos/neg channel pair. Yields one signed binary count
//  per element, presented with a valid/ready handshake. Sits after
//  stoch_matrix_mult (or any stochastic matrix producer) to return results to
//  the fixed-point domain.
// PARAMETERS
//  NUM_ROWS     2  matrix rows
//  NUM_COLS     2  matrix columns
//  WINDOW_LOG2  8  log2 of integration window length in cycles (>=1)
// PORTS
//  CLK        in   1                        clock, rising edge
//  nRST       in   1                        async active-low reset
//  start      in   1                        begin a new integration window
//  Y_p        in   [NUM_ROWS-1:0][NUM_COLS-1:0]  positive-channel bits
//  Y_m        in   [NUM_ROWS-1:0][NUM_COLS-1:0]  negative-channel bits
//  busy       out  1                        high while integrating
//  out_valid  out  1                        result matrix valid
//  out_ready  in   1                        consumer accepts result
//  count      out  [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2+1:0]  signed counts
// BEHAVIOUR
//  - One clock (CLK); reset nRST asynchronous, active-low. Reset values:
//    state=IDLE, busy=0, out_valid=0, count=0, window counter=0, all accumulators=0.
//  - FSM states IDLE, ACCUM, HOLD.
//  - IDLE: start=1 -> ACCUM. Accumulators and window counter clear on that edge.
//    Y_p/Y_m on the start cycle are NOT sampled.
//  - ACCUM: busy=1. Each cycle, per element: acc += Y_p - Y_m
//    (+1, -1 or 0; both high = 0).
//    - Exactly N=2**WINDOW_LOG2 samples are taken: cycles 1..N after start.
//    - On the N-th sample edge: count <= final acc (including that sample),
//      out_valid <= 1, state -> HOLD.
//    - start is ignored in ACCUM.
//  - Width: acc is signed WINDOW_LOG2+2 bits, range [-N,+N]. This is exact, with
//    no saturation or overflow possible.
//  - HOLD: busy=0. out_valid=1 and count stay stable until out_valid&&out_ready.
//    Inputs Y_p/Y_m are ignored.
//    - Handshake with start=0 -> IDLE, out_valid<=0.
//    - Handshake with start=1 (same cycle) -> ACCUM directly, out_valid<=0,
//      accumulators cleared. This gives back-to-back windows with no idle cycle.
//    - start without handshake in HOLD is ignored.
//  - count holds its last value after the handshake. It changes only at window
//    end or reset.
//  - Total latency: start edge to out_valid high = N+1 edges.
//  - Reset asserted mid-ACCUM or mid-HOLD aborts immediately. No partial result
//    is ever flagged valid.
// STRUCTURE
//  - Shared package stoch_pkg:
//    - typedef enum {IDLE, ACCUM, HOLD} stoch_dec_state_t
//    - function acc_width(int log2n) = log2n+2
//  - Sub-module stoch_decode_acc: one per element, generate loop over row/col.
//    - Ports: CLK, nRST, clr, en, p, m, acc[W+1:0] signed up/down counter.
//    - clr has priority over en.
//  - Top holds the FSM, the WINDOW_LOG2-bit window counter (terminal count
//    N-1) and the count output registers.
// TESTING (WINDOW_LOG2=4, N=16, 2x2 unless noted)
//  1. Reset: nRST low mid-run -> busy=0, out_valid=0, count all 0 on the same
//     cycle, without waiting for a CLK edge.
//  2. Constant streams: Y_p=all1,Y_m=0 -> count=+16. Y_p=0,Y_m=all1 -> -16.
//     Both all1 -> 0. out_valid rises 17 edges after start.
//  3. Per-element distinct patterns:
//     - [0][0] p alternating 1/0, m=0 -> +8
//     - [0][1] p=1 first 4 cycles only -> +4
//     - [1][0] m=1 every 4th cycle -> -4
//     - [1][1] p=1,m=1 all -> 0
//  4. Backpressure: out_ready=0 for 5 cycles after out_valid. Toggle Y_p/Y_m and
//     pulse start -> out_valid and count stable. out_ready=1 -> IDLE next edge.
//  5. Back-to-back: start=1 with the handshake cycle -> busy=1 next edge.
//     Second window's result is valid 16 edges later, with no extra idle cycle.
//  6. start during ACCUM (cycle 7) -> ignored; window still ends after 16
//     samples with the correct count.

Source files
------------

// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic matrix decoder.
//   stoch_dec_state_t : decoder FSM states (IDLE, ACCUM, HOLD)
//   acc_width()       : accumulator width for a 2**log2n sample window. The
//                       signed range [-N,+N] needs log2n+2 bits.
package stoch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } stoch_dec_state_t;

  function automatic int acc_width(input int log2n);
    return log2n + 2;
  endfunction

endpackage

// File: rtl/stoch_decode_acc.sv
// Per-element signed up/down counter for one pos/neg stochastic stream pair.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset (acc -> 0)
//   clr  : synchronous clear, wins over en
//   en   : add the current sample (+1 for p only, -1 for m only, else 0)
//   p, m : positive / negative channel bits
//   acc  : two's-complement running sum, WINDOW_LOG2+2 bits
module stoch_decode_acc
  import stoch_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   p,
  input  logic                   m,
  output logic [WINDOW_LOG2+1:0] acc
);

  localparam int ACC_W = acc_width(WINDOW_LOG2);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  // Both channels high cancel to zero.
  function automatic logic signed [ACC_W-1:0] step(input logic p_bit, input logic m_bit);
    logic signed [ACC_W-1:0] s;
    s = '0;
    if (p_bit && !m_bit) begin
      s = ACC_W'(1);
    end else if (m_bit && !p_bit) begin
      s = '1;
    end
    return s;
  endfunction

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + step(p, m);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/stoch_matrix_decode.sv
// Reader end of the stochastic matrix datapath. Integrates a NUM_ROWS x
// NUM_COLS matrix of signed (pos/neg pair) stochastic bitstreams over a window
// of N = 2**WINDOW_LOG2 cycles and presents one signed count per element with
// a valid/ready handshake.
//   CLK       : clock, rising edge
//   nRST      : asynchronous active-low reset
//   start     : begin a new window (IDLE, or HOLD together with the handshake)
//   Y_p, Y_m  : positive / negative channel bits per element
//   busy      : high while integrating
//   out_valid : result matrix valid, held until out_ready
//   out_ready : consumer accepts the result
//   count     : per-element two's-complement counts, range [-N,+N]
module stoch_matrix_decode
  import stoch_pkg::*;
#(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_COLS    = 2,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                                                 CLK,
  input  logic                                                 nRST,
  input  logic                                                 start,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                    Y_p,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                    Y_m,
  output logic                                                 busy,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2+1:0]   count
);

  localparam int                     ACC_W    = acc_width(WINDOW_LOG2);
  localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;

  stoch_dec_state_t state_q, state_d;
  logic [WINDOW_LOG2-1:0] win_q, win_d;
  logic busy_q, busy_d;
  logic out_valid_q, out_valid_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][ACC_W-1:0] count_q, count_d;

  logic clr;
  logic en;
  logic load;
  logic [ACC_W-1:0] acc_w [NUM_ROWS][NUM_COLS];

  // Same +1/-1/0 step the accumulators apply, so the final sample can be
  // folded into the captured count on the last window edge.
  function automatic logic [ACC_W-1:0] step_ext(input logic p_bit, input logic m_bit);
    logic [ACC_W-1:0] s;
    s = '0;
    if (p_bit && !m_bit) begin
      s = ACC_W'(1);
    end else if (m_bit && !p_bit) begin
      s = '1;
    end
    return s;
  endfunction

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      stoch_decode_acc #(
        .WINDOW_LOG2(WINDOW_LOG2)
      ) u_acc (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (clr),
        .en   (en),
        .p    (Y_p[r][c]),
        .m    (Y_m[r][c]),
        .acc  (acc_w[r][c])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    clr     = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        // The start cycle itself is not sampled: accumulators only clear here.
        if (start) begin
          state_d = ACCUM;
          clr     = 1'b1;
          win_d   = '0;
        end
      end
      ACCUM: begin
        en    = 1'b1;
        win_d = win_q + WINDOW_LOG2'(1);
        if (win_q == WIN_LAST) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_d = ACCUM;
            clr     = 1'b1;
            win_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d      = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  always_comb begin
    count_d = count_q;
    if (load) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          count_d[r][c] = acc_w[r][c] + step_ext(Y_p[r][c], Y_m[r][c]);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      win_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_stoch_matrix_decode.sv
module tb_stoch_matrix_decode;

  localparam int NR = 2;
  localparam int NC = 2;
  localparam int WL = 4;

  logic                         CLK;
  logic                         nRST;
  logic                         start;
  logic [NR-1:0][NC-1:0]        Y_p;
  logic [NR-1:0][NC-1:0]        Y_m;
  logic                         busy;
  logic                         out_valid;
  logic                         out_ready;
  logic [NR-1:0][NC-1:0][WL+1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  stoch_matrix_decode #(
    .NUM_ROWS   (NR),
    .NUM_COLS   (NC),
    .WINDOW_LOG2(WL)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .Y_p       (Y_p),
    .Y_m       (Y_m),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Element e = r*2 + c; bit k of pm/mm is the sample taken on window cycle k+1.
  typedef struct packed {
    logic [3:0][15:0] pm;
    logic [3:0][15:0] mm;
    logic [3:0][5:0]  ex;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_counts(input vec_t v, input string tag);
    for (int e = 0; e < 4; e++) begin
      chk($sformatf("%s count[%0d][%0d]", tag, e / 2, e % 2),
          int'(count[e/2][e%2]), int'(v.ex[e]));
    end
  endtask

  task automatic check_zero_state(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " count"}, int'(count), 0);
  endtask

  // Caller is at a negedge. Garbage on Y during the start cycle must be ignored.
  task automatic start_window();
    start = 1'b1;
    Y_p   = '1;
    Y_m   = '0;
    @(negedge CLK);
    start = 1'b0;
    chk("start busy", int'(busy), 1);
    chk("start out_valid", int'(out_valid), 0);
  endtask

  // Caller is at the negedge right after the start edge.
  task automatic feed(input vec_t v, input bit pulse7, input string tag);
    for (int k = 0; k < 16; k++) begin
      for (int e = 0; e < 4; e++) begin
        Y_p[e/2][e%2] = v.pm[e][k];
        Y_m[e/2][e%2] = v.mm[e][k];
      end
      start = pulse7 && (k == 6);
      @(negedge CLK);
      if (k == 14) begin
        chk({tag, " valid_before_16"}, int'(out_valid), 0);
        chk({tag, " busy_before_16"}, int'(busy), 1);
      end
    end
    start = 1'b0;
    chk({tag, " out_valid"}, int'(out_valid), 1);
    chk({tag, " busy_end"}, int'(busy), 0);
    check_counts(v, tag);
  endtask

  task automatic handshake(input bit s, input string tag);
    out_ready = 1'b1;
    start     = s;
    Y_p       = '1;
    Y_m       = '0;
    @(negedge CLK);
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, " hs out_valid"}, int'(out_valid), 0);
    chk({tag, " hs busy"}, int'(busy), int'(s));
  endtask

  initial begin
    vecs[0] = '{pm: {4{16'hFFFF}}, mm: '0, ex: {4{6'd16}}};
    vecs[1] = '{pm: '0, mm: {4{16'hFFFF}}, ex: {4{6'h30}}};
    vecs[2] = '{pm: {4{16'hFFFF}}, mm: {4{16'hFFFF}}, ex: '0};
    vecs[3] = '{pm: {16'hFFFF, 16'h0000, 16'h000F, 16'h5555},
                mm: {16'hFFFF, 16'h1111, 16'h0000, 16'h0000},
                ex: {6'd0, 6'h3C, 6'd4, 6'd8}};
    vecs[4] = '{pm: {16'hAAAA, 16'h0000, 16'h0001, 16'hFFFF},
                mm: {16'h5555, 16'h7FFF, 16'h0000, 16'h00FF},
                ex: {6'd0, 6'h31, 6'd1, 6'd8}};

    nRST      = 1'b0;
    start     = 1'b0;
    Y_p       = '0;
    Y_m       = '0;
    out_ready = 1'b0;

    @(negedge CLK);
    check_zero_state("reset");
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Table of windows, each ending with a plain handshake back to IDLE.
    for (int i = 0; i < 5; i++) begin
      start_window();
      feed(vecs[i], 1'b0, $sformatf("vec%0d", i));
      handshake(1'b0, $sformatf("vec%0d", i));
      check_counts(vecs[i], $sformatf("vec%0d post_hs", i));
    end

    // Backpressure: Y toggling and start pulses in HOLD must not disturb it.
    start_window();
    feed(vecs[3], 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      Y_p   = 4'($urandom);
      Y_m   = 4'($urandom);
      start = (i % 2) == 0;
      @(negedge CLK);
      chk($sformatf("bp hold%0d out_valid", i), int'(out_valid), 1);
      chk($sformatf("bp hold%0d busy", i), int'(busy), 0);
      check_counts(vecs[3], $sformatf("bp hold%0d", i));
    end
    start = 1'b0;
    handshake(1'b0, "bp");
    @(negedge CLK);
    chk("bp idle busy", int'(busy), 0);
    chk("bp idle out_valid", int'(out_valid), 0);

    // Back-to-back windows via start on the handshake cycle.
    start_window();
    feed(vecs[0], 1'b0, "b2b_a");
    handshake(1'b1, "b2b_a");
    feed(vecs[1], 1'b0, "b2b_b");
    handshake(1'b0, "b2b_b");

    // start raised on window cycle 7 is ignored.
    start_window();
    feed(vecs[4], 1'b1, "mid_start");
    handshake(1'b0, "mid_start");

    // Asynchronous reset in the middle of ACCUM (count is nonzero beforehand).
    start_window();
    for (int k = 0; k < 5; k++) begin
      Y_p = '1;
      Y_m = '0;
      @(negedge CLK);
    end
    #2 nRST = 1'b0;
    #1 check_zero_state("rst_accum");
    @(negedge CLK);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_accum after busy", int'(busy), 0);
    chk("rst_accum after out_valid", int'(out_valid), 0);

    // Asynchronous reset while holding a valid result.
    start_window();
    feed(vecs[0], 1'b0, "pre_rst_hold");
    #2 nRST = 1'b0;
    #1 check_zero_state("rst_hold");
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Recovery window after reset.
    start_window();
    feed(vecs[3], 1'b0, "recover");
    handshake(1'b0, "recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
